ls_shift_deserializer: RTL

- Serial-in / parallel-out counterpart to the board's universal parallel-load shift registers.
- Assembles WIDTH-bit words from a serial bit stream, in either shift direction.
- Transfers each completed word into an output holding register.
- Presents the word to downstream logic with a valid/ready handshake and a sticky overrun flag; used on the receive end of serialized video/sound data paths.

---
 rtl/ls_shift_deserializer_if.sv | 44 ++++
 rtl/ls_shift_deserializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ls_shift_deserializer_if.sv
// ---------------------------------------------------------------------------
// ls_shift_deserializer_if
//
// Groups the serial input side and the parallel output handshake of
// ls_shift_deserializer into one bundle. CK and CLR are kept as plain ports
// on the module itself.
//
// Signals:
//   SI, SEN, DIR, SYNC  serial data, shift enable, direction, frame restart
//   P, BUSY             live shift register and frame-in-progress flag
//   Q, Q_VALID, Q_READY holding register and its valid/ready handshake
//   OVR, OVR_CLR        sticky overrun flag and its synchronous clear
//   Q_PERR              parity error flag travelling with Q
//
// Modports:
//   master  the producer/consumer environment (drives SI..OVR_CLR)
//   slave   the deserializer itself
// ---------------------------------------------------------------------------
interface ls_shift_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             SI;
  logic             SEN;
  logic             DIR;
  logic             SYNC;
  logic [WIDTH-1:0] P;
  logic             BUSY;
  logic [WIDTH-1:0] Q;
  logic             Q_VALID;
  logic             Q_READY;
  logic             OVR;
  logic             OVR_CLR;
  logic             Q_PERR;

  modport master (
    output SI, SEN, DIR, SYNC, Q_READY, OVR_CLR,
    input  P, BUSY, Q, Q_VALID, OVR, Q_PERR
  );

  modport slave (
    input  SI, SEN, DIR, SYNC, Q_READY, OVR_CLR,
    output P, BUSY, Q, Q_VALID, OVR, Q_PERR
  );
endinterface

// File: rtl/ls_shift_deserializer.sv
// ---------------------------------------------------------------------------
// ls_shift_deserializer
//
// Serial-in / parallel-out shift register. Bits arriving on SI (sampled when
// SEN is high) are assembled into WIDTH-bit words in either direction. Each
// completed word is moved into a holding register Q that is offered to the
// consumer with a valid/ready handshake; a frame that completes while Q is
// still occupied and not being taken raises the sticky OVR flag.
//
// Ports:
//   CK        clock, rising edge
//   CLR       asynchronous active-high reset
//   bus       ls_shift_deserializer_if.slave (see interface for signals)
//
// Optional build macro:
//   LS_DESER_PARITY_CHK_EN  each frame carries one extra even-parity bit
//                           after the data bits; Q_PERR reports a mismatch.
//                           Undefined: frames are WIDTH bits, Q_PERR = 0.
//
// Handshake: Q_VALID high means Q holds an unconsumed word. The word is
// taken on a rising CK edge where Q_VALID && Q_READY. Q never changes while
// Q_VALID is high and the word has not been taken, except when a new frame
// completes on the very edge the old one is taken (back-to-back transfer).
// ---------------------------------------------------------------------------
module ls_shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                     CK,
  input  logic                     CLR,
  ls_shift_deserializer_if.slave   bus
);

`ifdef LS_DESER_PARITY_CHK_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  logic [WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             busy_q;
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;
  logic             ovr_q;
  logic             perr_q;

  logic [WIDTH-1:0] base_p;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             new_frame;
  logic             eff_dir;
  logic             frame_end;
  logic             ovr_set;
  logic             load_q;
  logic             perr_word;

  // --------------------------------------------------------------------
  // Shift path
  // --------------------------------------------------------------------
  always_comb begin
    // SYNC restarts the frame: the bit shifted on this edge (if any) is
    // bit 0 of a fresh frame and uses the DIR value presented now.
    new_frame = bus.SYNC || (cnt_q == '0);
    base_p    = bus.SYNC ? '0 : p_q;
    eff_dir   = new_frame ? bus.DIR : dir_q;
    shifted   = eff_dir ? {base_p[WIDTH-2:0], bus.SI}
                        : {bus.SI, base_p[WIDTH-1:1]};
    frame_end = bus.SEN && !bus.SYNC && (cnt_q == LAST_BIT);

    p_d   = p_q;
    cnt_d = cnt_q;
    dir_d = dir_q;

    if (bus.SEN) begin
`ifdef LS_DESER_PARITY_CHK_EN
      // The trailing parity bit is checked but never shifted into P.
      if (!frame_end) begin
        p_d = shifted;
      end
`else
      p_d = shifted;
`endif
      if (frame_end) begin
        cnt_d = '0;
      end else if (bus.SYNC) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (new_frame) begin
        dir_d = bus.DIR;
      end
    end else if (bus.SYNC) begin
      p_d   = '0;
      cnt_d = '0;
    end
  end

  // Completed word and its parity status on a frame-end edge.
  always_comb begin
`ifdef LS_DESER_PARITY_CHK_EN
    word      = p_q;
    perr_word = (^p_q) ^ bus.SI;
`else
    word      = shifted;
    perr_word = 1'b0;
`endif
  end

  // --------------------------------------------------------------------
  // Holding register / handshake
  // --------------------------------------------------------------------
  always_comb begin
    // Overrun only when the occupied word is not being taken this edge;
    // a simultaneous take-and-refill is a normal transfer.
    ovr_set = frame_end && q_valid_q && !bus.Q_READY;
    load_q  = frame_end && !ovr_set;
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      p_q    <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      busy_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (load_q) begin
        q_q    <= word;
        perr_q <= perr_word;
      end
      if (frame_end) begin
        q_valid_q <= 1'b1;
      end else if (q_valid_q && bus.Q_READY) begin
        q_valid_q <= 1'b0;
      end
    end
  end

  // Set has priority over clear so an overrun is never lost.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      ovr_q <= 1'b0;
    end else if (ovr_set) begin
      ovr_q <= 1'b1;
    end else if (bus.OVR_CLR) begin
      ovr_q <= 1'b0;
    end
  end

  assign bus.P       = p_q;
  assign bus.BUSY    = busy_q;
  assign bus.Q       = q_q;
  assign bus.Q_VALID = q_valid_q;
  assign bus.OVR     = ovr_q;
`ifdef LS_DESER_PARITY_CHK_EN
  assign bus.Q_PERR  = perr_q;
`else
  assign bus.Q_PERR  = 1'b0;
`endif

endmodule
